capture_buffer: RTL

//   Single-clock circular capture memory for the logic analyzer. Stores pre-trigger

---
 rtl/capture_buffer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/capture_buffer.sv
// capture_buffer: circular pre/post-trigger capture memory with oldest-first
// valid/ready readout of a DEPTH-sample window.
// Build option CAPTURE_DECIM_EN: adds decim[7:0]; only every (decim+1)-th
// sample_valid pulse is accepted while capturing.
module capture_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] pre_trig,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_data,
  input  logic                  trig,
`ifdef CAPTURE_DECIM_EN
  input  logic [7:0]            decim,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  input  logic                  rd_start,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE, S_READ} state_t;

  state_t                state_q, state_nxt;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, pre_q;
  logic [CW-1:0]         cnt, rd_cnt, ld_cnt;
  logic [CW-1:0]         post_len;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic                  capturing, accept_c;
  logic                  arm_go, rd_go, rd_fire, load_out, ren;
  logic                  q_valid;
  logic [DATA_WIDTH-1:0] ram_q;
  logic [DATA_WIDTH-1:0] ram [DEPTH];

  assign capturing  = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
  assign post_len   = CW'(DEPTH) - CW'(pre_q);
  assign start_addr = trig_addr - pre_q;

`ifdef CAPTURE_DECIM_EN
  logic [7:0] decim_q, dec_cnt;

  assign accept_c = capturing && sample_valid && !abort && (dec_cnt == 8'd0);

  // Sample divider: counts sample_valid pulses, accepts when the count is zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decim_q <= 8'd0;
      dec_cnt <= 8'd0;
    end else if (abort || arm_go) begin
      dec_cnt <= 8'd0;
      if (arm_go) decim_q <= decim;
    end else if (capturing && sample_valid) begin
      dec_cnt <= (dec_cnt == decim_q) ? 8'd0 : dec_cnt + 8'd1;
    end
  end
`else
  assign accept_c = capturing && sample_valid && !abort;
`endif

  // Next-state and read-pipeline control; abort overrides everything
  always_comb begin
    state_nxt = state_q;
    arm_go    = 1'b0;
    rd_go     = 1'b0;
    rd_fire   = rd_valid && rd_ready;
    load_out  = 1'b0;
    ren       = 1'b0;
    case (state_q)
      S_IDLE: if (arm) arm_go = 1'b1;
      S_PRE:  if (accept_c && (cnt + CW'(1)) == CW'(pre_q)) state_nxt = S_WAIT;
      S_WAIT: if (accept_c && trig) state_nxt = (post_len == CW'(1)) ? S_DONE : S_POST;
      S_POST: if (accept_c && (cnt + CW'(1)) == post_len) state_nxt = S_DONE;
      S_DONE: begin
        if (arm) begin
          arm_go = 1'b1;
        end else if (rd_start) begin
          rd_go     = 1'b1;
          state_nxt = S_READ;
        end
      end
      S_READ: begin
        load_out = q_valid && (!rd_valid || rd_ready);
        ren      = (!q_valid || load_out) && (rd_cnt != CW'(DEPTH));
        if (rd_fire && rd_last) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (arm_go) state_nxt = (pre_trig == '0) ? S_WAIT : S_PRE;
    if (abort) begin
      state_nxt = S_IDLE;
      arm_go    = 1'b0;
      rd_go     = 1'b0;
      load_out  = 1'b0;
      ren       = 1'b0;
    end
  end

  // State, status flags, capture pointers and the two-stage read pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_ptr    <= '0;
      cnt       <= '0;
      pre_q     <= '0;
      trig_addr <= '0;
      rd_ptr    <= '0;
      rd_cnt    <= '0;
      ld_cnt    <= '0;
      q_valid   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      rd_data   <= '0;
    end else begin
      state_q <= state_nxt;
      busy    <= (state_nxt == S_PRE) || (state_nxt == S_WAIT) || (state_nxt == S_POST);
      done    <= (state_nxt == S_DONE) || (state_nxt == S_READ);

      if (arm_go) begin
        wr_ptr <= '0;
        cnt    <= '0;
        pre_q  <= pre_trig;
      end else if (accept_c) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
        if (state_q == S_WAIT) begin
          if (trig) begin
            trig_addr <= wr_ptr;
            cnt       <= CW'(1);
          end
        end else begin
          cnt <= cnt + CW'(1);
        end
      end

      if (abort) begin
        q_valid  <= 1'b0;
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end else if (rd_go) begin
        rd_ptr   <= start_addr;
        rd_cnt   <= '0;
        ld_cnt   <= '0;
        q_valid  <= 1'b0;
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end else if (state_q == S_READ) begin
        if (ren) begin
          rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
          rd_cnt <= rd_cnt + CW'(1);
        end
        if (ren) q_valid <= 1'b1;
        else if (load_out) q_valid <= 1'b0;
        if (load_out) begin
          rd_data  <= ram_q;
          rd_valid <= 1'b1;
          rd_last  <= (ld_cnt == CW'(DEPTH - 1));
          ld_cnt   <= ld_cnt + CW'(1);
        end else if (rd_fire) begin
          rd_valid <= 1'b0;
          rd_last  <= 1'b0;
        end
      end
    end
  end

  // Sample memory: one write port for capture, one registered read port
  always_ff @(posedge clk) begin
    if (accept_c) ram[wr_ptr] <= sample_data;
    if (ren) ram_q <= ram[rd_ptr];
  end

endmodule
